// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_arbiter
// Purpose  : Register-file write-back controller: zero-fills the file after
//            reset, then round-robins the single write port between ALU and LSU.
// Revision : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              lsu_valid,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  output logic              lsu_ready,
  output logic              rf_wEn,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0] rf_dataIn,
  output logic              init_done,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic                c_gnt_alu  = 1'b0;
  localparam logic                c_gnt_lsu  = 1'b1;
  localparam int unsigned         c_last_idx = NUM_REGS - 1;
  localparam logic [ADDR_W:0]     c_ptr_last = c_last_idx[ADDR_W:0];
  localparam logic [ADDR_W:0]     c_ptr_one  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]    c_cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0]   c_rd_zero  = '0;

  state_t              r_state;
  logic [ADDR_W:0]     r_ptr;
  logic                r_last_grant;
  logic                r_wen;
  logic [ADDR_W-1:0]   r_rd;
  logic [DATA_W-1:0]   r_data;
  logic                r_init_done;
  logic [CNT_W-1:0]    r_stall;

  state_t              w_state_nxt;
  logic [ADDR_W:0]     w_ptr_nxt;
  logic                w_last_nxt;
  logic                w_wen_nxt;
  logic [ADDR_W-1:0]   w_rd_nxt;
  logic [DATA_W-1:0]   w_data_nxt;
  logic                w_done_nxt;
  logic [CNT_W-1:0]    w_stall_nxt;

  logic                w_run;
  logic                w_alu_gnt;
  logic                w_lsu_gnt;
  logic                w_stall_evt;

  // On a tie the requester that did not win last time is served.
  assign w_run       = (r_state == ST_RUN);
  assign w_alu_gnt   = w_run && alu_valid && (!lsu_valid || (r_last_grant == c_gnt_lsu));
  assign w_lsu_gnt   = w_run && lsu_valid && (!alu_valid || (r_last_grant == c_gnt_alu));
  assign w_stall_evt = w_run && ((alu_valid && !w_alu_gnt) || (lsu_valid && !w_lsu_gnt));

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_last_nxt  = r_last_grant;
    w_wen_nxt   = 1'b0;
    w_rd_nxt    = r_rd;
    w_data_nxt  = r_data;
    w_done_nxt  = r_init_done;
    w_stall_nxt = r_stall;
    case (r_state)
      ST_INIT: begin
        w_wen_nxt  = 1'b1;
        w_rd_nxt   = r_ptr[ADDR_W-1:0];
        w_data_nxt = '0;
        w_ptr_nxt  = r_ptr + c_ptr_one;
        if (r_ptr == c_ptr_last) begin
          w_state_nxt = ST_RUN;
          w_done_nxt  = 1'b1;
        end
      end
      ST_RUN: begin
        // x0 requests are consumed but never reach the register file.
        if (w_alu_gnt) begin
          w_last_nxt = c_gnt_alu;
          if (alu_rd != c_rd_zero) begin
            w_wen_nxt  = 1'b1;
            w_rd_nxt   = alu_rd;
            w_data_nxt = alu_data;
          end
        end else if (w_lsu_gnt) begin
          w_last_nxt = c_gnt_lsu;
          if (lsu_rd != c_rd_zero) begin
            w_wen_nxt  = 1'b1;
            w_rd_nxt   = lsu_rd;
            w_data_nxt = lsu_data;
          end
        end
        if (w_stall_evt && (r_stall != {CNT_W{1'b1}})) begin
          w_stall_nxt = r_stall + c_cnt_one;
        end
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_INIT;
      r_ptr        <= '0;
      r_last_grant <= c_gnt_lsu;
      r_wen        <= 1'b0;
      r_rd         <= '0;
      r_data       <= '0;
      r_init_done  <= 1'b0;
      r_stall      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      r_last_grant <= w_last_nxt;
      r_wen        <= w_wen_nxt;
      r_rd         <= w_rd_nxt;
      r_data       <= w_data_nxt;
      r_init_done  <= w_done_nxt;
      r_stall      <= w_stall_nxt;
    end
  end

  assign alu_ready = w_alu_gnt;
  assign lsu_ready = w_lsu_gnt;
  assign rf_wEn    = r_wen;
  assign rf_rd     = r_rd;
  assign rf_dataIn = r_data;
  assign init_done = r_init_done;
  assign stall_cnt = r_stall;

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_wb_arbiter
// Purpose  : Directed self-checking bench for rf_wb_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic        rf_wEn;
  logic [4:0]  rf_rd;
  logic [31:0] rf_dataIn;
  logic        init_done;
  logic [15:0] stall_cnt;

  int total;
  int bad;

  rf_wb_arbiter #(
    .DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .rf_wEn(rf_wEn), .rf_rd(rf_rd), .rf_dataIn(rf_dataIn),
    .init_done(init_done), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;

    tick();
    tick();
    chk("rst_wen",   rf_wEn,    0);
    chk("rst_rd",    rf_rd,     0);
    chk("rst_data",  rf_dataIn, 0);
    chk("rst_done",  init_done, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_ardy",  alu_ready, 0);
    chk("rst_lrdy",  lsu_ready, 0);
    rst = 1'b0;

    for (int k = 0; k < 32; k++) begin
      tick();
      chk("fill_wen",  rf_wEn,    1);
      chk("fill_rd",   rf_rd,     k);
      chk("fill_data", rf_dataIn, 0);
      chk("fill_done", init_done, (k == 31) ? 1 : 0);
    end
    tick();
    chk("idle_wen",   rf_wEn,    0);
    chk("idle_done",  init_done, 1);
    chk("idle_stall", stall_cnt, 0);

    // Contention: ALU wins the first tie after reset.
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h22;
    #1;
    chk("cont_ardy1", alu_ready, 1);
    chk("cont_lrdy1", lsu_ready, 0);
    tick();
    alu_valid = 1'b0;
    chk("cont_wen1",  rf_wEn,    1);
    chk("cont_rd1",   rf_rd,     3);
    chk("cont_dat1",  rf_dataIn, 32'h11);
    chk("cont_stall", stall_cnt, 1);
    #1;
    chk("cont_lrdy2", lsu_ready, 1);
    tick();
    lsu_valid = 1'b0;
    chk("cont_wen2",  rf_wEn,    1);
    chk("cont_rd2",   rf_rd,     4);
    chk("cont_dat2",  rf_dataIn, 32'h22);
    chk("cont_stal2", stall_cnt, 1);
    tick();
    chk("cont_wen3",  rf_wEn,    0);

    // Both held valid: grants alternate and the write port stays busy.
    alu_valid = 1'b1; lsu_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("b2b_wen", rf_wEn, 1);
      chk("b2b_rd",  rf_rd,  (k % 2 == 0) ? 3 : 4);
    end
    alu_valid = 1'b0; lsu_valid = 1'b0;
    chk("b2b_stall", stall_cnt, 5);
    tick();
    chk("b2b_idle", rf_wEn, 0);

    // Single ALU request.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    chk("one_ardy", alu_ready, 1);
    chk("one_lrdy", lsu_ready, 0);
    tick();
    alu_valid = 1'b0;
    chk("one_wen",  rf_wEn,    1);
    chk("one_rd",   rf_rd,     5);
    chk("one_data", rf_dataIn, 32'hDEADBEEF);
    tick();
    chk("one_wen0", rf_wEn,    0);

    // x0 request from LSU: consumed, not written.
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hFFFFFFFF;
    #1;
    chk("x0_lrdy", lsu_ready, 1);
    tick();
    lsu_valid = 1'b0;
    chk("x0_wen", rf_wEn, 0);

    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h33;
    lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h44;
    #1;
    chk("x0tie_ardy", alu_ready, 1);
    chk("x0tie_lrdy", lsu_ready, 0);
    tick();
    alu_valid = 1'b0;
    chk("x0tie_rd1", rf_rd, 1);
    tick();
    lsu_valid = 1'b0;
    chk("x0tie_rd2",   rf_rd,     2);
    chk("x0tie_dat2",  rf_dataIn, 32'h44);
    chk("x0tie_stall", stall_cnt, 6);
    tick();

    // Reset lands on the accept edge of an rd=9 write.
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
    #1;
    chk("mid_ardy", alu_ready, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    alu_valid = 1'b0;
    chk("mid_wen",   rf_wEn,    0);
    chk("mid_done",  init_done, 0);
    chk("mid_stall", stall_cnt, 0);

    // Refill, with an ALU request raised at fill cycle 3.
    for (int k = 0; k < 32; k++) begin
      tick();
      if (k == 3) begin
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hA5;
      end
      #1;
      chk("refill_rd",  rf_rd,  k);
      chk("refill_wen", rf_wEn, 1);
      if (k < 31) chk("refill_ardy", alu_ready, 0);
    end
    chk("refill_done",  init_done, 1);
    chk("refill_ardy2", alu_ready, 1);
    tick();
    alu_valid = 1'b0;
    chk("pend_wen",  rf_wEn,    1);
    chk("pend_rd",   rf_rd,     7);
    chk("pend_data", rf_dataIn, 32'hA5);
    tick();
    chk("pend_once",  rf_wEn,    0);
    chk("pend_stall", stall_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
